roundrobin_demux: RTL and testbench

Single-stream to multi-channel distributor: the counterpart of the round-robin merger. One tagged input stream (data word plus destination index) is steered into one of MUXOUT per-channel FIFOs. Each channel drains independently through a show-ahead valid/ack interface. Sits between the host/command deserializer and the per-driver consumers. Overflow and bad-destination words are dropped and counted.

---
 rtl/roundrobin_demux.sv | 138 +++++++++++++
 tb/tb_roundrobin_demux.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/roundrobin_demux.sv
`default_nettype none
// ============================================================================
// roundrobin_demux : tagged single stream steered into MUXOUT show-ahead FIFOs
// Rev 1.0
// ============================================================================
module roundrobin_demux #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int MUXOUT = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          din,
  input  logic [$clog2(MUXOUT)-1:0] dest,
  input  logic                      nd,
  output logic [WIDTH-1:0]          dout [0:MUXOUT-1],
  output logic [MUXOUT-1:0]         dval,
  input  logic [MUXOUT-1:0]         ack,
  output logic [MUXOUT-1:0]         full,
  output logic [15:0]               drop_count,
  output logic [15:0]               bad_dest_count
);

  localparam int DEST_W = $clog2(MUXOUT);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [15:0]      SAT_MAX  = 16'hFFFF;

  logic              stg_valid_q, stg_valid_d;
  logic [WIDTH-1:0]  stg_data_q,  stg_data_d;
  logic [DEST_W-1:0] stg_dest_q,  stg_dest_d;
  logic [15:0]       drop_q,      drop_d;
  logic [15:0]       bad_q,       bad_d;

  logic              dest_ok;
  logic [MUXOUT-1:0] wr_any;
  logic              overflow;
  logic              bad_word;

  // Input stage: one word accepted every cycle nd is high, no back-pressure.
  always_comb begin
    stg_valid_d = nd;
    stg_data_d  = stg_data_q;
    stg_dest_d  = stg_dest_q;
    if (nd) begin
      stg_data_d = din;
      stg_dest_d = dest;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      stg_dest_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      stg_dest_q  <= stg_dest_d;
    end
  end

  assign dest_ok  = (int'(stg_dest_q) < MUXOUT);
  assign bad_word = stg_valid_q && !dest_ok;
  assign overflow = stg_valid_q && dest_ok && (wr_any == '0);

  for (genvar k = 0; k < MUXOUT; k++) begin : g_chan
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             sel;
    logic             pop_en;
    logic             wr_en;

    assign sel    = stg_valid_q && (stg_dest_q == DEST_W'(k));
    assign pop_en = ack[k] && (count_q != '0);
    // A full channel still takes the word when its head leaves on the same edge.
    assign wr_en  = sel && ((count_q != CNT_FULL) || pop_en);
    assign wr_any[k] = wr_en;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= stg_data_q;
    end

    assign dout[k] = mem_q[rd_ptr_q];
    assign dval[k] = (count_q != '0);
    assign full[k] = (count_q == CNT_FULL);
  end

  always_comb begin
    drop_d = drop_q;
    bad_d  = bad_q;
    if (overflow && (drop_q != SAT_MAX)) drop_d = drop_q + 16'd1;
    if (bad_word && (bad_q != SAT_MAX))  bad_d  = bad_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
      bad_q  <= '0;
    end else begin
      drop_q <= drop_d;
      bad_q  <= bad_d;
    end
  end

  assign drop_count     = drop_q;
  assign bad_dest_count = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_roundrobin_demux.sv
`default_nettype none
// Bench for roundrobin_demux: directed table, hand sequences, randomized run
// against a queue-based reference model; plus a MUXOUT=3 instance for bad dest.
module tb_roundrobin_demux;
  localparam int D = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] din = '0;
  logic [0:0]  dest = '0;
  logic        nd = 1'b0;
  logic [15:0] dout [0:1];
  logic [1:0]  dval;
  logic [1:0]  ack = '0;
  logic [1:0]  full;
  logic [15:0] drop_count, bad_dest_count;

  logic [15:0] din3 = '0;
  logic [1:0]  dest3 = '0;
  logic        nd3 = 1'b0;
  logic [15:0] dout3 [0:2];
  logic [2:0]  dval3;
  logic [2:0]  ack3 = '0;
  logic [2:0]  full3;
  logic [15:0] drop3, bad3;

  roundrobin_demux #(.WIDTH(16), .DEPTH(D), .MUXOUT(2)) dut (
    .clock(clock), .reset_n(reset_n), .din(din), .dest(dest), .nd(nd),
    .dout(dout), .dval(dval), .ack(ack), .full(full),
    .drop_count(drop_count), .bad_dest_count(bad_dest_count));

  roundrobin_demux #(.WIDTH(16), .DEPTH(4), .MUXOUT(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .din(din3), .dest(dest3), .nd(nd3),
    .dout(dout3), .dval(dval3), .ack(ack3), .full(full3),
    .drop_count(drop3), .bad_dest_count(bad3));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the one-word staging slot.
  logic [15:0] mq0[$], mq1[$], got0[$], got1[$];
  logic        m_sv = 1'b0;
  logic [15:0] m_sdat = '0;
  logic        m_sdest = 1'b0;
  int          m_drop = 0;

  typedef struct {
    logic        nd;
    logic [15:0] din;
    logic        dest;
    logic [1:0]  ack;
    logic [1:0]  e_dval;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete(); got0.delete(); got1.delete();
    m_sv = 1'b0; m_drop = 0;
  endtask

  // One clock: record DUT pops, advance the model, then compare after the edge.
  task automatic step();
    bit p0, p1;
    if (ack[0] && dval[0]) got0.push_back(dout[0]);
    if (ack[1] && dval[1]) got1.push_back(dout[1]);
    @(posedge clock);
    p0 = ack[0] && (mq0.size() != 0);
    p1 = ack[1] && (mq1.size() != 0);
    if (p0) void'(mq0.pop_front());
    if (p1) void'(mq1.pop_front());
    if (m_sv) begin
      if (m_sdest == 1'b0) begin
        if (mq0.size() < D) mq0.push_back(m_sdat);
        else if (m_drop < 65535) m_drop++;
      end else begin
        if (mq1.size() < D) mq1.push_back(m_sdat);
        else if (m_drop < 65535) m_drop++;
      end
    end
    m_sv = nd; m_sdat = din; m_sdest = dest[0];
    #1;
    chk("model_dval", 32'(dval), 32'({mq1.size() != 0, mq0.size() != 0}));
    chk("model_full", 32'(full), 32'({mq1.size() == D, mq0.size() == D}));
    if (mq0.size() != 0) chk("model_dout0", 32'(dout[0]), 32'(mq0[0]));
    if (mq1.size() != 0) chk("model_dout1", 32'(dout[1]), 32'(mq1[0]));
    chk("model_drop", 32'(drop_count), 32'(m_drop));
    chk("model_bad", 32'(bad_dest_count), 32'd0);
  endtask

  task automatic do_reset();
    nd = 1'b0; ack = '0; nd3 = 1'b0; ack3 = '0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'hA001, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 16'hB002, 1'b1, 2'b00, 2'b01, 16'hA001, 16'h0000};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b11, 16'hA001, 16'hB002};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 2'b11, 2'b00, 16'h0000, 16'h0000};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000};

    #2;
    do_reset();
    chk("reset_dval", 32'(dval), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_drop", 32'(drop_count), 32'd0);
    chk("reset_bad", 32'(bad_dest_count), 32'd0);

    // Basic steer
    for (int i = 0; i < 5; i++) begin
      nd = tbl[i].nd; din = tbl[i].din; dest = tbl[i].dest; ack = tbl[i].ack;
      step();
      chk("tbl_dval", 32'(dval), 32'(tbl[i].e_dval));
      if (tbl[i].e_dval[0]) chk("tbl_dout0", 32'(dout[0]), 32'(tbl[i].e_d0));
      if (tbl[i].e_dval[1]) chk("tbl_dout1", 32'(dout[1]), 32'(tbl[i].e_d1));
    end
    chk("tbl_drop", 32'(drop_count), 32'd0);

    // Overflow: 10 words to channel 0, no ack
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      nd = 1'b1; dest = 1'b0; din = 16'h1000 + 16'(i);
      step();
    end
    nd = 1'b0;
    step(); step();
    chk("ovf_full0", 32'(full[0]), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_dval1", 32'(dval[1]), 32'd0);
    ack = 2'b01;
    for (int i = 0; i < 10; i++) step();
    ack = 2'b00;
    chk("ovf_drain_n", 32'(got0.size()), 32'd8);
    for (int j = 0; j < got0.size(); j++)
      chk("ovf_drain_word", 32'(got0[j]), 32'(16'h1001 + 16'(j)));

    // Simultaneous pop at full
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      nd = 1'b1; dest = 1'b1; din = 16'h2000 + 16'(i);
      step();
    end
    nd = 1'b0; step();
    chk("paf_full1", 32'(full[1]), 32'd1);
    nd = 1'b1; dest = 1'b1; din = 16'h2009; step();
    nd = 1'b0; ack = 2'b10; step();
    ack = 2'b00;
    chk("paf_full1_after", 32'(full[1]), 32'd1);
    chk("paf_drop", 32'(drop_count), 32'd0);
    got1.delete();
    ack = 2'b10;
    for (int i = 0; i < 9; i++) step();
    ack = 2'b00;
    chk("paf_drain_n", 32'(got1.size()), 32'd8);
    for (int j = 0; j < got1.size(); j++)
      chk("paf_drain_word", 32'(got1[j]), 32'(16'h2002 + 16'(j)));

    // Interleaved streams, ack[0] held, ack[1] low
    do_reset();
    ack = 2'b01;
    for (int i = 0; i < 32; i++) begin
      nd = 1'b1; dest = 1'((i % 2));
      din = ((i % 2) == 1) ? 16'h0200 + 16'(i / 2) : 16'h0100 + 16'(i / 2);
      step();
    end
    nd = 1'b0;
    step(); step(); step();
    ack = 2'b00;
    chk("ilv_n0", 32'(got0.size()), 32'd16);
    for (int j = 0; j < got0.size(); j++)
      chk("ilv_word0", 32'(got0[j]), 32'(16'h0100 + 16'(j)));
    chk("ilv_full1", 32'(full[1]), 32'd1);
    chk("ilv_drop", 32'(drop_count), 32'd8);
    chk("ilv_dval0", 32'(dval[0]), 32'd0);

    // Reset mid-operation: 5 words held on channel 0, one staged
    for (int i = 1; i <= 6; i++) begin
      nd = 1'b1; dest = 1'b0; din = 16'h3000 + 16'(i);
      step();
    end
    nd = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dval", 32'(dval), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_bad", 32'(bad_dest_count), 32'd0);
    @(posedge clock); #1;
    chk("arst_dval_hold", 32'(dval), 32'd0);
    reset_n = 1'b1;
    model_clear();
    nd = 1'b1; dest = 1'b0; din = 16'h5A5A; step();
    nd = 1'b0; step();
    chk("post_rst_dval", 32'(dval), 32'd1);
    chk("post_rst_dout0", 32'(dout[0]), 32'h5A5A);
    ack = 2'b01; step();
    ack = 2'b00; step();
    chk("post_rst_empty", 32'(dval), 32'd0);
    chk("post_rst_n", 32'(got0.size()), 32'd1);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      nd   = ($urandom_range(0, 99) < 70);
      dest = 1'($urandom_range(0, 1));
      din  = 16'($urandom);
      ack  = {($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 55)};
      step();
    end
    nd = 1'b0; ack = 2'b00;

    // Bad destination on the three-channel instance
    do_reset();
    nd3 = 1'b1; dest3 = 2'd3; din3 = 16'hDEAD;
    @(posedge clock); #1;
    nd3 = 1'b0;
    @(posedge clock); #1;
    chk("bad3_count", 32'(bad3), 32'd1);
    chk("bad3_dval", 32'(dval3), 32'd0);
    chk("bad3_drop", 32'(drop3), 32'd0);
    nd3 = 1'b1; dest3 = 2'd2; din3 = 16'hC0DE;
    @(posedge clock); #1;
    nd3 = 1'b0;
    @(posedge clock); #1;
    chk("ch2_dval", 32'(dval3), 32'd4);
    chk("ch2_dout", 32'(dout3[2]), 32'hC0DE);
    chk("ch2_bad_hold", 32'(bad3), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
